// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive-side buffer.
// Optional overflow counter in uart_rx_flow is enabled by UART_RX_FLOW_OVF_COUNT_EN.
package uart_pkg;

   typedef enum logic {
      RTS_GO   = 1'b0,
      RTS_STOP = 1'b1
   } rts_state_e;

   localparam int DefWidth    = 8;
   localparam int DefDepth    = 16;
   localparam int DefHighMark = 12;
   localparam int DefLowMark  = 4;
   localparam int OvfCntW     = 16;

endpackage

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: Depth x Width register array, sync write, async read.
// No reset on storage; contents are qualified by the owner's count.
module rx_fifo_mem #(
   parameter int Width = 8,
   parameter int Depth = 16
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(Depth)-1:0] waddr_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic [$clog2(Depth)-1:0] raddr_i,
   output logic [Width-1:0]         rdata_o
);

   logic [Width-1:0] r_mem [Depth];

   // Write the accepted byte into its slot
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/uart_rx_flow.sv
// uart_rx_flow: FWFT byte FIFO with RTS watermark hysteresis and drop flag.
// Define UART_RX_FLOW_OVF_COUNT_EN to add the saturating overflow_count_o port.
module uart_rx_flow
   import uart_pkg::*;
#(
   parameter int Width    = DefWidth,
   parameter int Depth    = DefDepth,
   parameter int HighMark = DefHighMark,
   parameter int LowMark  = DefLowMark
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [Width-1:0]           rx_data_i,
   input  logic                       rx_valid_i,
   output logic [Width-1:0]           data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output logic                       rts_o,
   output logic                       overflow_o,
   input  logic                       clear_i
`ifdef UART_RX_FLOW_OVF_COUNT_EN
   ,
   output logic [OvfCntW-1:0]         overflow_count_o
`endif
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);

   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
   localparam logic [CntW-1:0] HighCnt = CntW'(HighMark);
   localparam logic [CntW-1:0] LowCnt  = CntW'(LowMark);

   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_count;
   rts_state_e      r_rts_state;
   logic            r_overflow;

   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [CntW-1:0] w_count_next;

   assign w_full       = (r_count == FullCnt);
   assign w_pop        = (r_count != '0) && ready_i;
   assign w_push       = rx_valid_i && (!w_full || w_pop);
   assign w_drop       = rx_valid_i && w_full && !w_pop;
   assign w_count_next = r_count + CntW'(w_push) - CntW'(w_pop);

   rx_fifo_mem #(
      .Width (Width),
      .Depth (Depth)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (w_push),
      .waddr_i (r_wr_ptr),
      .wdata_i (rx_data_i),
      .raddr_i (r_rd_ptr),
      .rdata_o (data_o)
   );

   // Advance pointers and occupancy on accepted push/pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
      end
   end

   // RTS hysteresis: judge the occupancy this edge will produce
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rts_state <= RTS_STOP;
      end else begin
         unique case (r_rts_state)
            RTS_STOP: if (w_count_next <= LowCnt)  r_rts_state <= RTS_GO;
            RTS_GO:   if (w_count_next >= HighCnt) r_rts_state <= RTS_STOP;
            default:  r_rts_state <= RTS_STOP;
         endcase
      end
   end

   // Sticky drop flag; a drop outranks a same-cycle clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clear_i) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef UART_RX_FLOW_OVF_COUNT_EN
   logic [OvfCntW-1:0] r_ovf_cnt;

   // Saturating drop counter; clear with a coincident drop leaves 1
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ovf_cnt <= '0;
      end else if (clear_i) begin
         r_ovf_cnt <= OvfCntW'(w_drop);
      end else if (w_drop && (r_ovf_cnt != '1)) begin
         r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
   end

   assign overflow_count_o = r_ovf_cnt;
`endif

   assign valid_o    = (r_count != '0);
   assign count_o    = r_count;
   assign rts_o      = (r_rts_state == RTS_STOP);
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_uart_rx_flow.sv
// tb_uart_rx_flow: directed vectors for uart_rx_flow (default parameters).
// Covers UART_RX_FLOW_OVF_COUNT_EN when the macro is defined at build time.
module tb_uart_rx_flow;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic [4:0] count_o;
   logic       rts_o;
   logic       overflow_o;
   logic       clear_i;
`ifdef UART_RX_FLOW_OVF_COUNT_EN
   logic [15:0] overflow_count_o;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   uart_rx_flow dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .count_o    (count_o),
      .rts_o      (rts_o),
      .overflow_o (overflow_o),
      .clear_i    (clear_i)
`ifdef UART_RX_FLOW_OVF_COUNT_EN
      ,
      .overflow_count_o (overflow_count_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni     = 1'b0;
      rx_data_i  = '0;
      rx_valid_i = 1'b0;
      ready_i    = 1'b0;
      clear_i    = 1'b0;

      // reset then idle
      #23;
      chk("rst_rts", 32'(rts_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
`ifdef UART_RX_FLOW_OVF_COUNT_EN
      chk("rst_ovfcnt", 32'(overflow_count_o), 32'd0);
`endif
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      chk("idle_rts", 32'(rts_o), 32'd0);
      chk("idle_valid", 32'(valid_o), 32'd0);
      chk("idle_count", 32'(count_o), 32'd0);

      // 12 pushes, no consumer: RTS rises on the 12th
      for (int i = 1; i <= 12; i++) begin
         rx_data_i  = 8'(i);
         rx_valid_i = 1'b1;
         tick();
         chk("fill_rts", 32'(rts_o), (i >= 12) ? 32'd1 : 32'd0);
      end
      rx_valid_i = 1'b0;
      chk("fill_count", 32'(count_o), 32'd12);
      chk("fill_valid", 32'(valid_o), 32'd1);

      // drain in order; RTS falls when count reaches 4
      ready_i = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         chk("drain_data", 32'(data_o), 32'(j));
         tick();
         chk("drain_count", 32'(count_o), 32'(12 - j));
         chk("drain_rts", 32'(rts_o), ((12 - j) > 4) ? 32'd1 : 32'd0);
      end
      chk("drain_valid", 32'(valid_o), 32'd0);
      ready_i = 1'b0;

      // 17 pushes: last byte dropped
      for (int i = 0; i < 17; i++) begin
         rx_data_i  = 8'(8'hA0 + i);
         rx_valid_i = 1'b1;
         tick();
         chk("ovf_flag", 32'(overflow_o), (i == 16) ? 32'd1 : 32'd0);
      end
      rx_valid_i = 1'b0;
      chk("ovf_count", 32'(count_o), 32'd16);
      chk("ovf_rts", 32'(rts_o), 32'd1);
`ifdef UART_RX_FLOW_OVF_COUNT_EN
      chk("ovf_cnt1", 32'(overflow_count_o), 32'd1);
`endif
      ready_i = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk("ovf_drain", 32'(data_o), 32'(8'hA0 + j));
         tick();
      end
      ready_i = 1'b0;
      chk("ovf_empty", 32'(valid_o), 32'd0);
      chk("ovf_sticky", 32'(overflow_o), 32'd1);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("ovf_clear", 32'(overflow_o), 32'd0);
`ifdef UART_RX_FLOW_OVF_COUNT_EN
      chk("ovf_cnt0", 32'(overflow_count_o), 32'd0);
`endif

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) begin
         rx_data_i  = 8'(8'h10 + i);
         rx_valid_i = 1'b1;
         tick();
      end
      chk("full_count", 32'(count_o), 32'd16);
      rx_data_i  = 8'h55;
      rx_valid_i = 1'b1;
      ready_i    = 1'b1;
      tick();
      rx_valid_i = 1'b0;
      chk("both_count", 32'(count_o), 32'd16);
      chk("both_ovf", 32'(overflow_o), 32'd0);
      for (int j = 1; j <= 16; j++) begin
         chk("both_drain", 32'(data_o),
             (j == 16) ? 32'h55 : 32'(8'h10 + j));
         tick();
      end
      ready_i = 1'b0;
      chk("both_empty", 32'(valid_o), 32'd0);

      // asynchronous reset with 9 entries stored
      for (int i = 0; i < 9; i++) begin
         rx_data_i  = 8'(8'h70 + i);
         rx_valid_i = 1'b1;
         tick();
      end
      rx_valid_i = 1'b0;
      chk("pre_rst_count", 32'(count_o), 32'd9);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_count", 32'(count_o), 32'd0);
      chk("arst_rts", 32'(rts_o), 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      chk("post_rts", 32'(rts_o), 32'd0);
      chk("post_valid", 32'(valid_o), 32'd0);
      chk("post_count", 32'(count_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_flow.md
# uart_rx_flow

Receive-side buffer between the UART receiver and the image pipeline's AXI-stream input. Accepts one byte per `rx_valid_i` strobe (no backpressure available on the serial side), stores bytes in a first-word-fall-through FIFO, and presents them to the pipeline over valid/ready. Drives the UART RTS line with high/low-watermark hysteresis so the ESP pauses before the FIFO fills, and records dropped bytes.

## Interface
Parameters:
- `Width`, 8: byte width.
- `Depth`, 16: FIFO entries. Power of two, at least 4.
- `HighMark`, 12: occupancy at which RTS asserts. Requires `LowMark < HighMark < Depth`.
- `LowMark`, 4: occupancy at which RTS deasserts.

Ports (clock and reset first):
- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_data_i` in `Width`: received byte.
- `rx_valid_i` in 1: one-cycle strobe, byte present.
- `data_o` out `Width`: head-of-FIFO byte.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer accepts `data_o`.
- `count_o` out `$clog2(Depth+1)`: current occupancy.
- `rts_o` out 1: 1 = sender must pause.
- `overflow_o` out 1: sticky, a byte was dropped.
- `clear_i` in 1: clears `overflow_o`.
- `overflow_count_o` out 16: present only with `UART_RX_FLOW_OVF_COUNT_EN`.

## Operation
- Push: `rx_valid_i && (count < Depth || pop)`. Pop: `valid_o && ready_i`.
- `count_next = count + push - pop`. Simultaneous push and pop leave `count` unchanged; this includes the full case, where the byte is accepted.
- Pointers are `$clog2(Depth)` bits wide and wrap naturally. Data order is strictly preserved.
- `valid_o = (count != 0)`. `data_o = mem[rd_ptr]` combinationally (FWFT). `data_o` is don't-care while `valid_o = 0`.
- Drop: `rx_valid_i` while full and no pop. The byte is discarded and pointers and memory are unchanged.
- RTS is a registered two-state FSM:
  - STOP → GO when `count_next <= LowMark`.
  - GO → STOP when `count_next >= HighMark`.
  - Otherwise the state holds.
  - `rts_o = (state == STOP)`.
- `overflow_o` sets on a drop and clears on `clear_i`. If a drop and `clear_i` occur in the same cycle, set wins.
- Reset values: pointers 0, `count_o` 0, `valid_o` 0, `overflow_o` 0, `overflow_count_o` 0, RTS state STOP (`rts_o` = 1). Memory is not reset.
- Reset mid-operation discards contents immediately and asynchronously. `valid_o` drops without any handshake.

## Timing
- Write latency: a byte pushed at edge N gives `valid_o` = 1 after edge N. There is no same-cycle pass-through from an empty FIFO.
- Pop takes effect at the accepting edge; the next entry is visible after that edge.
- `rts_o` changes on the edge where `count` crosses a mark, i.e. the same edge `count_o` updates.
- First edge after reset release: `rts_o` goes 0, because `count_next` = 0 ≤ `LowMark`.
- `Depth - HighMark` is the in-flight slack: bytes the ESP may still send after RTS asserts.
- Throughput: one push and one pop per cycle.

## Configuration
- `UART_RX_FLOW_OVF_COUNT_EN` defined:
  - Adds `overflow_count_o`, a 16-bit counter that increments on each dropped byte and saturates at 0xFFFF.
  - `clear_i` zeroes it. If a drop and `clear_i` coincide, the result is 1.
- Not defined: port and counter are absent. `overflow_o` behaves identically either way.

## Structure
- Shared package `uart_pkg`:
  - RTS FSM state enum (`RTS_GO`, `RTS_STOP`).
  - Default `Width`, `Depth` and watermark constants.
  - Counter width constant (16).
- Sub-module `rx_fifo_mem`:
  - `Depth` × `Width` register array.
  - Synchronous write port, asynchronous read port.
  - No reset.
- Pointer, count, FSM and overflow logic live in `uart_rx_flow`.

## Test plan
- Reset then idle: `rts_o` = 1 during reset, 0 on the first edge after release. `valid_o` = 0 and `count_o` = 0.
- Push 0x01..0x0C with `ready_i` = 0: `rts_o` rises on the edge of the 12th push. `count_o` = 12.
- From 12 entries, set `ready_i` = 1: bytes emerge as 0x01, 0x02, … in order. `rts_o` falls on the edge where `count_o` becomes 4.
- Push 17 bytes (0xA0..0xB0) with `ready_i` = 0:
  - 0xB0 is dropped and `overflow_o` = 1 the next cycle.
  - Draining yields 0xA0..0xAF.
  - `clear_i` clears the flag.
  - With the macro, `overflow_count_o` = 1.
- Full FIFO with simultaneous push of 0x55 and pop: no drop, `count_o` stays 16, and 0x55 appears last on drain.
- Assert `rst_ni` low with 9 entries stored: `valid_o` and `count_o` go 0 immediately. After release, the FIFO is empty and `rts_o` = 0.
